pc_fetch_sequencer: RTL and testbench
=====================================

PC_FETCH_SEQUENCER -- requirements
Module: pc_fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  fetch address (current PC).
REQ-006 imem_ready  input  1  imem_instr valid this cycle.
REQ-007 imem_instr  input  32  fetched instruction word.
REQ-008 instr_valid  output  1  instr_out/pc_out hold a presented instruction.
REQ-009 instr_out  output  32  presented instruction.
REQ-010 pc_out  output  32  address of instr_out.
REQ-011 stall  input  1  downstream hold; instruction not consumed while high.
REQ-012 branch_taken  input  1  take branch for the presented instruction.
REQ-013 branch_offset  input  32  sign-extended word offset.
REQ-014 jump  input  1  J-type jump for the presented instruction.
REQ-015 jr  input  1  jump-register for the presented instruction.
REQ-016 jr_target  input  32  register jump address.
REQ-017 fetch_error  output  1  sticky misaligned-jr flag.
REQ-018 instr_count  output  32  consumed-instruction counter.

Function
REQ-019 States SHALL be IDLE, FETCH, HOLD; IDLE -> FETCH unconditionally the next cycle.
REQ-020 In FETCH, imem_req=1 and imem_addr=pc; on imem_ready, instr_out<=imem_instr, pc_out<=pc, instr_valid<=1, next state HOLD.
REQ-021 In FETCH without imem_ready, the FSM SHALL stay in FETCH with imem_addr stable.
REQ-022 In HOLD, imem_req=0, instr_valid=1; stall=1 keeps HOLD and ignores all redirect inputs.
REQ-023 In HOLD with stall=0, the instruction is consumed: pc<=next_pc, instr_valid<=0, next state FETCH.
REQ-024 next_pc priority SHALL be jr > jump > branch_taken > sequential.
REQ-025 sequential = pc_out+4; branch = pc_out+4+(branch_offset<<2); jump = {seq[31:28], instr_out[25:0], 2'b00}; jr = {jr_target[31:2], 2'b00}; all modulo 2^32.
REQ-026 PC 32'hFFFF_FFFC sequential SHALL wrap to 32'h0000_0000.
REQ-027 jr consumed with jr_target[1:0]!=0 SHALL set fetch_error, held until reset.
REQ-028 imem_ready outside FETCH SHALL be ignored.
REQ-029 Minimum throughput: one instruction per 2 cycles (ready in first FETCH cycle, stall=0).

Reset
REQ-030 reset SHALL dominate all inputs, including mid-fetch and in HOLD; imem_ready in a reset cycle is ignored.
REQ-031 Reset values: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_out=0, pc_out=RESET_PC, fetch_error=0, instr_count=0.

Configuration
REQ-032 Macro PC_SEQ_PERF_EN defined: instr_count increments by 1 per consumed instruction, wrapping 32'hFFFF_FFFF -> 0.
REQ-033 Macro undefined: instr_count tied to 0, no counter flops; port list unchanged.

Structure
REQ-034 Package pc_seq_pkg SHALL hold the state enum, PC width (32), instruction width (32) and RESET_PC default.
REQ-035 Sub-module jump_target_gen (combinational) SHALL form the jump address from pc+4 and instr[25:0].

Verification
REQ-036 Reset, imem_ready=1 always, stall=0, no redirects -> imem_addr 0x0, 0x4, 0x8 on each FETCH cycle; instr_valid every 2nd cycle.
REQ-037 pc_out=0x1000_0010, instr_out[25:0]=26'h0000040, jump=1 -> next imem_addr 0x1000_0100.
REQ-038 pc_out=0x0000_0020, branch_taken=1, branch_offset=-4 -> next imem_addr 0x0000_0014; with jump=1 also, jump target wins.
REQ-039 stall=1 for 3 cycles in HOLD with jr=1 toggling -> instr_out/pc_out unchanged, no request; stall=0 then consumes once.
REQ-040 jr=1, jr_target=0x0000_0043 -> imem_addr 0x0000_0040, fetch_error=1 until reset.
REQ-041 reset asserted mid-FETCH with imem_ready=1 -> no capture, instr_valid=0, restart at RESET_PC; PC_SEQ_PERF_EN: instr_count=0 after reset, equals consumed count otherwise.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared widths, reset address and FSM states for the fetch sequencer
package pc_seq_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/jump_target_gen.sv
// rtl/jump_target_gen.sv - J-type target: region of pc+4 joined with the 26-bit word index
module jump_target_gen
    import pc_seq_pkg::*;
(
    input  logic [PC_W-1:0] pc_plus4,
    input  logic [25:0]     instr_index,
    output logic [PC_W-1:0] target
);

    assign target = {pc_plus4[PC_W-1:PC_W-4], instr_index, 2'b00};

endmodule

// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - fetch/present/consume sequencer; PC_SEQ_PERF_EN adds the consumed-instruction counter
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_offset,
    input  logic               jump,
    input  logic               jr,
    input  logic [PC_W-1:0]    jr_target,
    output logic               fetch_error,
    output logic [31:0]        instr_count
);

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] branch_pc;
    logic [PC_W-1:0] jump_pc;
    logic [PC_W-1:0] jr_pc;
    logic [PC_W-1:0] next_pc;
    logic            consume;

    // Redirects are relative to the presented instruction, not the fetch pointer.
    assign seq_pc    = pc_out + 32'd4;
    assign branch_pc = seq_pc + (branch_offset << 2);
    assign jr_pc     = {jr_target[PC_W-1:2], 2'b00};

    jump_target_gen u_jump_target_gen (
        .pc_plus4    (seq_pc),
        .instr_index (instr_out[25:0]),
        .target      (jump_pc)
    );

    always_comb begin
        next_pc = seq_pc;
        if (jr) begin
            next_pc = jr_pc;
        end else if (jump) begin
            next_pc = jump_pc;
        end else if (branch_taken) begin
            next_pc = branch_pc;
        end
    end

    assign consume   = (state == HOLD) && !stall;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            pc_out      <= RESET_PC;
            fetch_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    imem_req <= 1'b1;
                    state    <= FETCH;
                end
                FETCH: begin
                    if (imem_ready) begin
                        instr_out   <= imem_instr;
                        pc_out      <= pc;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (consume) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                        if (jr && (jr_target[1:0] != 2'b00)) begin
                            fetch_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

`ifdef PC_SEQ_PERF_EN
    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (consume) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign instr_count = count_q;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - randomized scoreboard bench for pc_fetch_sequencer against a program-order model
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_instr;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic        jr;
    logic [31:0] jr_target;
    logic        fetch_error;
    logic [31:0] instr_count;

    always #5 clk = ~clk;

    pc_fetch_sequencer #(.RESET_PC(RPC)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_instr    (imem_instr),
        .instr_valid   (instr_valid),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jr            (jr),
        .jr_target     (jr_target),
        .fetch_error   (fetch_error),
        .instr_count   (instr_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
        int unsigned cnt;
    } exp_t;

    typedef struct {
        int          stalls;
        logic        br;
        logic [31:0] off;
        logic        j;
        logic        jr;
        logic [31:0] jt;
    } act_t;

    exp_t        sb[$];
    act_t        acts[$];
    logic [31:0] mem_ovr [logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    bit          fast = 0;

    logic [31:0] cur_pc;
    logic [31:0] cur_instr;
    logic        m_err;
    int unsigned m_cnt;
    bit          drv_seen = 0;
    int          stall_left = 0;
    act_t        act;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Program-order model: where the next instruction comes from, given the decision made on this one.
    task automatic model_consume(input act_t a);
        logic [31:0] seq;
        logic [31:0] nxt;
        seq = cur_pc + 32'd4;
        if (a.jr)       nxt = a.jt - (a.jt % 4);
        else if (a.j)   nxt = (seq & 32'hF000_0000) | ((cur_instr & 32'h03FF_FFFF) * 4);
        else if (a.br)  nxt = seq + a.off * 4;
        else            nxt = seq;
        if (a.jr && (a.jt % 4 != 0)) m_err = 1'b1;
        m_cnt++;
        cur_pc    = nxt;
        cur_instr = mem_word(nxt);
        sb.push_back('{nxt, cur_instr, m_err, m_cnt});
    endtask

    task automatic release_reset();
        sb.delete();
        drv_seen   = 0;
        stall_left = 0;
        m_err      = 1'b0;
        m_cnt      = 0;
        cur_pc     = RPC;
        cur_instr  = mem_word(RPC);
        sb.push_back('{RPC, cur_instr, 1'b0, 0});
        reset = 1'b0;
    endtask

    task automatic drive_cycle();
        @(negedge clk);
        #1;
        imem_ready    = fast ? 1'b1 : ($urandom_range(3) != 0);
        imem_instr    = imem_req ? mem_word(imem_addr) : $urandom;
        branch_taken  = 1'($urandom_range(1));
        jump          = 1'($urandom_range(1));
        jr            = 1'($urandom_range(1));
        branch_offset = $urandom;
        jr_target     = $urandom;
        stall         = 1'($urandom_range(1));
        if (instr_valid) begin
            if (!drv_seen) begin
                drv_seen = 1;
                if (acts.size() > 0) begin
                    act = acts.pop_front();
                end else begin
                    act.stalls = fast ? 0 : int'($urandom_range(2));
                    act.br     = !fast && ($urandom_range(3) == 0);
                    act.off    = 32'($urandom_range(64)) - 32'd32;
                    act.j      = !fast && ($urandom_range(7) == 0);
                    act.jr     = !fast && ($urandom_range(7) == 0);
                    act.jt     = $urandom & (($urandom_range(7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
                end
                stall_left = act.stalls;
            end
            if (stall_left > 0) begin
                stall     = 1'b1;
                jr        = 1'(stall_left % 2);
                jr_target = 32'h0000_0003;
                stall_left--;
            end else begin
                stall         = 1'b0;
                branch_taken  = act.br;
                branch_offset = act.off;
                jump          = act.j;
                jr            = act.jr;
                jr_target     = act.jt;
                model_consume(act);
                drv_seen = 0;
            end
        end else begin
            drv_seen = 0;
        end
    endtask

    exp_t e;
    exp_t last;
    bit   prev_valid = 0;
    bit   seen_any = 0;

    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 0;
            seen_any   = 0;
        end else begin
            if (imem_req) begin
                check("valid_during_fetch", {31'd0, instr_valid}, 32'd0);
                if (sb.size() > 0) check("imem_addr", imem_addr, sb[0].pc);
                else begin
                    checks++;
                    errors++;
                    $display("FAIL fetch_unexpected: got addr %h expected no fetch", imem_addr);
                end
            end
            if (instr_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL present_unexpected: got pc %h expected none", pc_out);
                end else begin
                    e = sb.pop_front();
                    last = e;
                    check("pc_out", pc_out, e.pc);
                    check("instr_out", instr_out, e.instr);
                    check("fetch_error", {31'd0, fetch_error}, {31'd0, e.err});
`ifdef PC_SEQ_PERF_EN
                    check("instr_count", instr_count, e.cnt);
`else
                    check("instr_count", instr_count, 32'd0);
`endif
                end
                seen_any = 1;
            end else if (instr_valid) begin
                check("hold_pc", pc_out, last.pc);
                check("hold_instr", instr_out, last.instr);
                check("hold_no_req", {31'd0, imem_req}, 32'd0);
            end
            if (fast && seen_any)
                check("throughput", {31'd0, instr_valid}, {31'd0, !prev_valid});
            prev_valid = instr_valid;
        end
    end

    initial begin
        reset = 1'b1;
        imem_ready = 1'b1; imem_instr = 32'h1234_5678; stall = 1'b0;
        branch_taken = 1'b0; branch_offset = '0; jump = 1'b0; jr = 1'b0; jr_target = '0;
        mem_ovr[32'h1000_0010] = 32'hFC00_0040;

        repeat (2) @(negedge clk);
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_imem_addr", imem_addr, RPC);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr_out", instr_out, 32'd0);
        check("rst_pc_out", pc_out, RPC);
        check("rst_fetch_error", {31'd0, fetch_error}, 32'd0);
        check("rst_instr_count", instr_count, 32'd0);
        #1;
        release_reset();

        fast = 1;
        repeat (14) drive_cycle();
        fast = 0;

        acts.push_back('{0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h1000_0010});
        acts.push_back('{0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0});
        acts.push_back('{0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0020});
        acts.push_back('{0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0});
        acts.push_back('{0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0020});
        acts.push_back('{0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'd0});
        acts.push_back('{3, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0});
        acts.push_back('{0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0043});
        acts.push_back('{0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFC});
        acts.push_back('{0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0});
        for (int i = 0; i < 400 && acts.size() > 0; i++) drive_cycle();
        if (acts.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL directed_timeout: got %0d actions left expected 0", acts.size());
        end
        repeat (10) drive_cycle();
        check("fetch_error_sticky", {31'd0, fetch_error}, 32'd1);

        repeat (3000) drive_cycle();

        for (int i = 0; i < 20 && !imem_req; i++) drive_cycle();
        check("mid_fetch_reached", {31'd0, imem_req}, 32'd1);
        reset = 1'b1;
        imem_ready = 1'b1;
        imem_instr = 32'hDEAD_BEEF;
        stall = 1'b0;
        @(negedge clk);
        check("mid_rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("mid_rst_imem_addr", imem_addr, RPC);
        check("mid_rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("mid_rst_instr_out", instr_out, 32'd0);
        check("mid_rst_pc_out", pc_out, RPC);
        check("mid_rst_fetch_error", {31'd0, fetch_error}, 32'd0);
        check("mid_rst_instr_count", instr_count, 32'd0);
        #1;
        release_reset();

        repeat (400) drive_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
